// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two requesters.
// Round-robin grant in IDLE, one op in flight, fixed IDLE -> EXEC -> RESP
// sequence, registered response held stable under backpressure.

// Small combinational ALU behind the arbiter.
// The function codes it knows are add, sub, and, and BEQ.
// Unknown codes give dataOut = 0 and compTrue = 0.
// compTrue is only asserted by the BEQ compare.
module alu #(
    parameter int BIT_WIDTH = 32,
    parameter int FUNC_BITS = 5
) (
    input  logic [FUNC_BITS-1:0] func,
    input  logic [BIT_WIDTH-1:0] dataIn1,
    input  logic [BIT_WIDTH-1:0] dataIn2,
    output logic [BIT_WIDTH-1:0] dataOut,
    output logic                 compTrue
);
    localparam logic [FUNC_BITS-1:0] F_ADD = FUNC_BITS'(5'b00000);
    localparam logic [FUNC_BITS-1:0] F_SUB = FUNC_BITS'(5'b00001);
    localparam logic [FUNC_BITS-1:0] F_AND = FUNC_BITS'(5'b00100);
    localparam logic [FUNC_BITS-1:0] F_BEQ = FUNC_BITS'(5'b10001);

    // Function decode; add/sub wrap naturally at BIT_WIDTH.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        dataOut  = '0;
        compTrue = 1'b0;
        case (func)
            F_ADD:   dataOut  = dataIn1 + dataIn2;
            F_SUB:   dataOut  = dataIn1 - dataIn2;
            F_AND:   dataOut  = dataIn1 & dataIn2;
            F_BEQ:   compTrue = (dataIn1 == dataIn2);
            default: dataOut  = '0;
        endcase
    end
endmodule

module alu_share_arbiter #(
    parameter int BIT_WIDTH = 32,
    parameter int FUNC_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [FUNC_BITS-1:0] req0_func,
    input  logic [BIT_WIDTH-1:0] req0_a,
    input  logic [BIT_WIDTH-1:0] req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [FUNC_BITS-1:0] req1_func,
    input  logic [BIT_WIDTH-1:0] req1_a,
    input  logic [BIT_WIDTH-1:0] req1_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [BIT_WIDTH-1:0] rsp_data,
    output logic                 rsp_comp,
    output logic                 busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_last_grant;
    logic [FUNC_BITS-1:0] r_op_func;
    logic [BIT_WIDTH-1:0] r_op_a;
    logic [BIT_WIDTH-1:0] r_op_b;
    logic                 r_op_id;
    logic                 r_rsp_valid;
    logic                 r_rsp_id;
    logic [BIT_WIDTH-1:0] r_rsp_data;
    logic                 r_rsp_comp;

    logic                 w_idle;
    logic                 w_grant_valid;
    logic                 w_grant_id;
    logic [BIT_WIDTH-1:0] w_alu_out;
    logic                 w_alu_comp;

    // The shared ALU only ever sees the captured op registers.
    alu #(
        .BIT_WIDTH(BIT_WIDTH),
        .FUNC_BITS(FUNC_BITS)
    ) u_alu (
        .func    (r_op_func),
        .dataIn1 (r_op_a),
        .dataIn2 (r_op_b),
        .dataOut (w_alu_out),
        .compTrue(w_alu_comp)
    );

    // Round-robin pick: a lone requester wins outright, a tie goes to the
    // requester that was not granted last time.
    always_comb begin
        w_idle        = (r_state == S_IDLE) && !reset;
        w_grant_valid = req0_valid || req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else begin
            w_grant_id = req1_valid;
        end
    end

    // Ready is combinational and only ever offered while idle.
    // It is held low during reset so that no handshake can complete then.
    assign req0_ready = w_idle && w_grant_valid && (w_grant_id == 1'b0);
    assign req1_ready = w_idle && w_grant_valid && (w_grant_id == 1'b1);

    // Control FSM, op capture and registered response in one sequential block.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_op_func    <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_id      <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_comp   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_op_func    <= w_grant_id ? req1_func : req0_func;
                        r_op_a       <= w_grant_id ? req1_a    : req0_a;
                        r_op_b       <= w_grant_id ? req1_b    : req0_b;
                        r_op_id      <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_data  <= w_alu_out;
                    r_rsp_comp  <= w_alu_comp;
                    r_rsp_id    <= r_op_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    // Data, id and comp stay untouched until the consumer takes them.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_comp  = r_rsp_comp;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter.
// Drivers feed per-requester op queues.
// A negedge monitor models the arbitration and pushes expected results on
// every accept, then pops and compares them on every response handshake.
module tb_alu_share_arbiter;
    localparam int BW = 32;
    localparam int FB = 5;
    localparam logic [4:0] F_ADD = 5'b00000;
    localparam logic [4:0] F_SUB = 5'b00001;
    localparam logic [4:0] F_AND = 5'b00100;
    localparam logic [4:0] F_BEQ = 5'b10001;

    typedef struct {
        logic [4:0]    func;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
    } op_t;

    typedef struct {
        bit            id;
        logic [4:0]    func;
        logic [BW-1:0] data;
        bit            comp;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [FB-1:0] req0_func, req1_func;
    logic [BW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_comp, busy;
    logic [BW-1:0] rsp_data;

    op_t  stim0[$];
    op_t  stim1[$];
    exp_t exp_q[$];
    bit   acc0, acc1;
    int   gap_max = 0;
    bit   rand_ready = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_share_arbiter #(.BIT_WIDTH(BW), .FUNC_BITS(FB)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func(req0_func),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func(req1_func),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_comp(rsp_comp), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from the function's arithmetic meaning.
    function automatic exp_t model(input bit id, input op_t op);
        exp_t e;
        e.id   = id;
        e.func = op.func;
        e.comp = (op.func == F_BEQ) && (op.a == op.b);
        case (op.func)
            F_ADD:   e.data = op.a + op.b;
            F_SUB:   e.data = op.a - op.b;
            F_AND:   e.data = op.a & op.b;
            default: e.data = '0;
        endcase
        return e;
    endfunction

    // Requester 0: holds valid and operands until accepted.
    initial begin : drv0
        int gap;
        gap = 0;
        req0_valid = 0; req0_func = '0; req0_a = '0; req0_b = '0;
        forever begin
            @(posedge clk); #1;
            if (acc0) begin
                acc0 = 0;
                stim0.delete(0);
                gap = $urandom_range(0, gap_max);
            end
            if (gap > 0) begin
                gap--;
                req0_valid = 0;
            end else if (stim0.size() > 0) begin
                req0_valid = 1;
                req0_func = stim0[0].func; req0_a = stim0[0].a; req0_b = stim0[0].b;
            end else begin
                req0_valid = 0;
            end
        end
    end

    // Requester 1: same behaviour as requester 0.
    initial begin : drv1
        int gap;
        gap = 0;
        req1_valid = 0; req1_func = '0; req1_a = '0; req1_b = '0;
        forever begin
            @(posedge clk); #1;
            if (acc1) begin
                acc1 = 0;
                stim1.delete(0);
                gap = $urandom_range(0, gap_max);
            end
            if (gap > 0) begin
                gap--;
                req1_valid = 0;
            end else if (stim1.size() > 0) begin
                req1_valid = 1;
                req1_func = stim1[0].func; req1_a = stim1[0].a; req1_b = stim1[0].b;
            end else begin
                req1_valid = 0;
            end
        end
    end

    // Random consumer backpressure, used only during the random phase.
    always @(posedge clk) begin
        #1;
        if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor / scoreboard.
    initial begin : mon
        int   cyc, acc_cyc;
        bit   last, prev_valid, prev_hs, prev_id, prev_comp, eid;
        logic [BW-1:0] prev_data;
        exp_t e;
        cyc = 0; acc_cyc = -100; last = 1;
        prev_valid = 0; prev_hs = 0; prev_id = 0; prev_comp = 0; prev_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                last = 1; prev_valid = 0; prev_hs = 0;
            end else begin
                if (prev_hs)
                    check(!busy && !rsp_valid, "idle_after_rsp", {busy, rsp_valid}, 0);
                if (prev_valid && !prev_hs)
                    check(rsp_valid && rsp_data == prev_data && rsp_id == prev_id
                          && rsp_comp == prev_comp, "rsp_hold",
                          {rsp_valid, rsp_id, rsp_comp, rsp_data},
                          {1'b1, prev_id, prev_comp, prev_data});
                if (rsp_valid && !prev_valid)
                    check(cyc == acc_cyc + 2, "latency", cyc - acc_cyc, 2);
                if (busy) begin
                    if (req0_valid || req1_valid)
                        check(!req0_ready && !req1_ready, "no_ready_busy",
                              {req0_ready, req1_ready}, 0);
                end else if (req0_valid || req1_valid) begin
                    eid = (req0_valid && req1_valid) ? !last : req1_valid;
                    check(req0_ready == !eid && req1_ready == eid, "grant",
                          {req1_ready, req0_ready}, eid ? 2 : 1);
                    last = eid;
                    acc_cyc = cyc;
                end
                if (req0_valid && req0_ready && stim0.size() > 0) begin
                    exp_q.push_back(model(0, stim0[0])); acc0 = 1;
                end
                if (req1_valid && req1_ready && stim1.size() > 0) begin
                    exp_q.push_back(model(1, stim1[0])); acc1 = 1;
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check(0, "unexpected_rsp", rsp_id, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check(rsp_id == e.id, "rsp_id", rsp_id, e.id);
                        if (e.func == F_BEQ)
                            check(rsp_comp == e.comp, "rsp_comp", rsp_comp, e.comp);
                        else
                            check(rsp_data == e.data && rsp_comp == e.comp, "rsp_data",
                                  {rsp_comp, rsp_data}, {e.comp, e.data});
                    end
                end
                prev_valid = rsp_valid;
                prev_hs    = rsp_valid && rsp_ready;
                prev_id    = rsp_id;
                prev_comp  = rsp_comp;
                prev_data  = rsp_data;
            end
        end
    end

    function automatic op_t mk(input logic [4:0] f, input logic [BW-1:0] a,
                               input logic [BW-1:0] b);
        op_t o;
        o.func = f; o.a = a; o.b = b;
        return o;
    endfunction

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((stim0.size() > 0 || stim1.size() > 0 || exp_q.size() > 0
                || rsp_valid || busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(n < 4000, name, n, 4000);
    endtask

    task automatic wait_posedge_until_busy(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!busy && n < 50);
        check(busy, name, busy, 1);
    endtask

    initial begin : main
        int n;
        op_t o;
        reset = 1; rsp_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({rsp_valid, rsp_id, rsp_comp, busy, req0_ready, req1_ready} == 0
              && rsp_data == 0, "reset_state",
              {rsp_valid, rsp_id, rsp_comp, busy, rsp_data}, 0);
        @(posedge clk); #1 reset = 0;

        // Tie straight after reset: grants 0,1,0,1.
        @(negedge clk);
        stim0.push_back(mk(F_ADD, 1, 2));  stim1.push_back(mk(F_ADD, 12, 0));
        stim0.push_back(mk(F_ADD, 1, 2));  stim1.push_back(mk(F_ADD, 12, 0));
        wait_drain("drain_tie");

        // Single requests, including wrap-around.
        stim0.push_back(mk(F_ADD, 2, 3));
        wait_drain("drain_add");
        stim1.push_back(mk(F_ADD, 32'hFFFF_FFFE, 3));
        wait_drain("drain_addneg");
        stim0.push_back(mk(F_SUB, 5, 2));
        wait_drain("drain_sub");
        stim0.push_back(mk(F_SUB, 0, 1));
        stim1.push_back(mk(F_AND, 32'hF0F0_1234, 32'h0FF0_FFFF));
        wait_drain("drain_sub_and");
        stim0.push_back(mk(F_BEQ, 2, 2));
        stim0.push_back(mk(F_BEQ, 2, 3));
        wait_drain("drain_beq");

        // Backpressure: hold the response for 4 cycles while req1 waits.
        @(posedge clk); #1 rsp_ready = 0;
        stim0.push_back(mk(F_ADD, 32'h7FFF_FFFF, 1));
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rsp_valid && n < 50);
        check(rsp_valid, "bp_rsp_seen", rsp_valid, 1);
        stim1.push_back(mk(F_SUB, 10, 4));
        repeat (4) @(posedge clk);
        #1;
        check(rsp_valid && busy && !req1_ready, "bp_still_held",
              {rsp_valid, busy, req1_ready}, 3'b110);
        rsp_ready = 1;
        wait_drain("drain_bp");

        // Reset while the op is in EXEC: that op must never respond.
        stim0.push_back(mk(F_ADD, 100, 200));
        wait_posedge_until_busy("exec_reached");
        check(!rsp_valid, "in_exec", rsp_valid, 0);
        reset = 1;
        @(posedge clk); #1 reset = 0;
        exp_q.delete();
        @(negedge clk);
        check(!rsp_valid && !busy, "after_mid_reset", {rsp_valid, busy}, 0);
        repeat (4) begin
            @(negedge clk);
            check(!rsp_valid, "no_rsp_after_reset", rsp_valid, 0);
        end
        stim0.push_back(mk(F_ADD, 7, 8));  stim1.push_back(mk(F_SUB, 9, 9));
        wait_drain("drain_tie_after_reset");

        // Random traffic with gaps and random backpressure.
        gap_max = 2;
        rand_ready = 1;
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 3))
                0: o.func = F_ADD;
                1: o.func = F_SUB;
                2: o.func = F_AND;
                default: o.func = F_BEQ;
            endcase
            o.a = $urandom;
            o.b = ($urandom_range(0, 1) != 0) ? o.a : $urandom;
            if ($urandom_range(0, 1) != 0) stim0.push_back(o);
            else                           stim1.push_back(o);
        end
        wait_drain("drain_random");
        rand_ready = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
